// File: rtl/reg_file_pkg.sv
// Shared constants, types and sizing helper for the multi-port register file.
package reg_file_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;

    typedef logic [DEF_ADDR_W-1:0] regAddr_t;
    typedef logic [DEF_DATA_W-1:0] regData_t;

    function automatic int unsigned depthOf(input int unsigned addrW);
        return 32'd1 << addrW;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: writeback releases, issue reserves; a same-cycle
// reserve overrides a release of the same register.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic [NUM_WR-1:0]        wrEn,
    input  logic [NUM_WR*ADDR_W-1:0] wrAddr,
    input  logic                     rsvEn,
    input  logic [ADDR_W-1:0]        rsvAddr,
    output logic [2**ADDR_W-1:0]     busyVec
);

    localparam int unsigned DEPTH = depthOf(ADDR_W);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busyNext;

    always_comb begin
        busyNext = busy;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (wrEn[j]) begin
                busyNext[wrAddr[j*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (rsvEn) begin
            busyNext[rsvAddr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busyNext[0] = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busyNext;
        end
    end

    assign busyVec = busy;

endmodule

// File: rtl/reg_file_mp_sb.sv
// Multi-port register file with busy scoreboard for the pipelined MIPS core.
// Optional write-through forwarding: define REG_FILE_BYPASS_EN.
module reg_file_mp_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [2**ADDR_W-1:0]     busy_vec
);

    localparam int unsigned DEPTH = depthOf(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [2**ADDR_W-1:0] busyVec;
    logic [ADDR_W-1:0] rdA;
    logic [DATA_W-1:0] rdD;
    logic rdB;

    reg_scoreboard #(
        .ADDR_W  (ADDR_W),
        .NUM_WR  (NUM_WR),
        .ZERO_REG(ZERO_REG)
    ) uScoreboard (
        .clock  (clock),
        .rst_n  (rst_n),
        .wrEn   (wr_en),
        .wrAddr (wr_addr),
        .rsvEn  (rsv_en),
        .rsvAddr(rsv_addr),
        .busyVec(busyVec)
    );

    assign busy_vec = busyVec;

    // Ascending port order: the last non-blocking assignment, i.e. the highest index, wins.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && !(ZERO_REG != 0 && wr_addr[j*ADDR_W +: ADDR_W] == '0)) begin
                    mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rdA     = '0;
        rdD     = '0;
        rdB     = 1'b0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rdA = rd_addr[i*ADDR_W +: ADDR_W];
            rdD = mem[rdA];
            rdB = busyVec[rdA];
`ifdef REG_FILE_BYPASS_EN
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == rdA) begin
                    rdD = wr_data[j*DATA_W +: DATA_W];
                    rdB = rsv_en && (rsv_addr == rdA);
                end
            end
`endif
            // Reset gating keeps forwarded write data off the outputs while rst_n is low.
            if ((ZERO_REG != 0 && rdA == '0) || !rst_n) begin
                rdD = '0;
                rdB = 1'b0;
            end
            rd_data[i*DATA_W +: DATA_W] = rdD;
            rd_busy[i] = rdB;
        end
    end

endmodule

// File: tb/tb_reg_file_mp_sb.sv
// Directed vector bench for reg_file_mp_sb (2 read / 2 write ports, ZERO_REG=1).
module tb_reg_file_mp_sb;
    import reg_file_pkg::*;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [31:0] busy_vec;

    int passCnt = 0;
    int totalCnt = 0;

    reg_file_mp_sb #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .NUM_RD  (2),
        .NUM_WR  (2),
        .ZERO_REG(1)
    ) dut (
        .clock   (clock),
        .rst_n   (rst_n),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_busy (rd_busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rsv_en  (rsv_en),
        .rsv_addr(rsv_addr),
        .busy_vec(busy_vec)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  wrEn;
        regAddr_t    wa0;
        regData_t    wd0;
        regAddr_t    wa1;
        regData_t    wd1;
        logic        rsvEn;
        regAddr_t    ra;
        regAddr_t    r0;
        regAddr_t    r1;
        regData_t    ed0;
        regData_t    ed1;
        logic [1:0]  eBusy;
        logic [31:0] eVec;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(input logic [1:0] wrEn, input regAddr_t wa0, input regData_t wd0,
                                input regAddr_t wa1, input regData_t wd1, input logic rsvEn,
                                input regAddr_t ra, input regAddr_t r0, input regAddr_t r1,
                                input regData_t ed0, input regData_t ed1, input logic [1:0] eBusy,
                                input logic [31:0] eVec);
        vec_t v;
        v.wrEn = wrEn; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.rsvEn = rsvEn; v.ra = ra; v.r0 = r0; v.r1 = r1;
        v.ed0 = ed0; v.ed1 = ed1; v.eBusy = eBusy; v.eVec = eVec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) begin
            passCnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] we, input regAddr_t wa0, input regData_t wd0,
                         input regAddr_t wa1, input regData_t wd1, input logic re,
                         input regAddr_t ra, input regAddr_t r0, input regAddr_t r1);
        wr_en = we;
        wr_addr = {wa1, wa0};
        wr_data = {wd1, wd0};
        rsv_en = re;
        rsv_addr = ra;
        rd_addr = {r1, r0};
    endtask

    task automatic chkRead(input string tag, input regData_t d0, input regData_t d1,
                           input logic [1:0] b, input logic [31:0] vec);
        chk({tag, ".rd0"}, rd_data[31:0], d0);
        chk({tag, ".rd1"}, rd_data[63:32], d1);
        chk({tag, ".busy"}, {30'd0, rd_busy}, {30'd0, b});
        chk({tag, ".vec"}, busy_vec, vec);
    endtask

    initial begin
        // Reads are sampled before the edge, so they show state from earlier cycles.
        vecs[0]  = mk(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd2,
                      32'h0, 32'h0, 2'b00, 32'h0);
        vecs[1]  = mk(2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222, 1'b0, 5'd0, 5'd6, 5'd5,
                      32'h0, 32'hDEADBEEF, 2'b00, 32'h0);
        vecs[2]  = mk(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b1, 5'd0, 5'd7, 5'd0,
                      32'h22222222, 32'h0, 2'b00, 32'h0);
        vecs[3]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd5,
                      32'h0, 32'hDEADBEEF, 2'b00, 32'h0);
        vecs[4]  = mk(2'b10, 5'd0, 32'h0, 5'd9, 32'h5, 1'b1, 5'd9, 5'd9, 5'd0,
                      BYP ? 32'h5 : 32'h0, 32'h0, 2'b01, 32'h200);
        vecs[5]  = mk(2'b01, 5'd9, 32'h6, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd7,
                      BYP ? 32'h6 : 32'h5, 32'h22222222, BYP ? 2'b00 : 2'b01, 32'h200);
        vecs[6]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0,
                      32'h6, 32'h0, 2'b00, 32'h0);
        vecs[7]  = mk(2'b01, 5'd3, 32'hA5A5A5A5, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3,
                      BYP ? 32'hA5A5A5A5 : 32'h0, BYP ? 32'hA5A5A5A5 : 32'h0, 2'b00, 32'h0);
        vecs[8]  = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd7,
                      32'hA5A5A5A5, 32'h22222222, 2'b00, 32'h0);
        vecs[9]  = mk(2'b11, 5'd4, 32'h12345678, 5'd10, 32'hCAFEF00D, 1'b0, 5'd0, 5'd10, 5'd1,
                      BYP ? 32'hCAFEF00D : 32'h0, 32'h0, 2'b00, 32'h0);
        vecs[10] = mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd10,
                      32'h12345678, 32'hCAFEF00D, 2'b00, 32'h0);

        rst_n = 1'b0;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd7);
        repeat (2) @(posedge clock);
        #1 chkRead("reset", 32'h0, 32'h0, 2'b00, 32'h0);
        @(negedge clock);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clock);
            drive(vecs[i].wrEn, vecs[i].wa0, vecs[i].wd0, vecs[i].wa1, vecs[i].wd1,
                  vecs[i].rsvEn, vecs[i].ra, vecs[i].r0, vecs[i].r1);
            #2 chkRead($sformatf("vec%0d", i), vecs[i].ed0, vecs[i].ed1, vecs[i].eBusy, vecs[i].eVec);
        end

        // r4 is now reserved; assert reset mid-cycle with writes and a reserve pending.
        @(negedge clock);
        drive(2'b11, 5'd4, 32'hFFFF0000, 5'd11, 32'h0BADF00D, 1'b1, 5'd4, 5'd10, 5'd4);
        #1 chkRead("preRst", 32'hCAFEF00D, BYP ? 32'hFFFF0000 : 32'h12345678, 2'b10, 32'h10);
        rst_n = 1'b0;
        #1 chkRead("inRst", 32'h0, 32'h0, 2'b00, 32'h0);
        @(negedge clock);
        rst_n = 1'b1;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd4);
        #1 chkRead("postRst", 32'h0, 32'h0, 2'b00, 32'h0);

        @(negedge clock);
        drive(2'b01, 5'd4, 32'h00000077, 5'd0, 32'h0, 1'b0, 5'd0, 5'd11, 5'd5);
        @(negedge clock);
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd4);
        #1 chkRead("firstEdge", 32'h77, 32'h77, 2'b00, 32'h0);

        for (int r = 0; r < 32; r += 2) begin
            rd_addr = {5'(r + 1), 5'(r)};
            #1;
            chk($sformatf("sweep r%0d", r), rd_data[31:0], (r == 4) ? 32'h77 : 32'h0);
            chk($sformatf("sweep r%0d", r + 1), rd_data[63:32], 32'h0);
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/reg_file_mp_sb.md
Name: reg_file_mp_sb

Overview:
Parametrised multi-port register file for the pipelined MIPS datapath, successor to the single-cycle two-read/one-write file.
- NUM_RD asynchronous read ports and NUM_WR synchronous write ports.
- An integrated per-register busy scoreboard: issue reserves a destination register; writeback releases it.
- Sits between decode (reads, reserve) and writeback (writes); feeds hazard detection through rd_busy.

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 2, number of write ports (1..2)
ZERO_REG, 1, when 1, register 0 reads as zero, ignores writes and is never busy

Ports:
clock  input  1  single clock; all state updates on its rising edge
rst_n  input  1  asynchronous, active-low reset
rd_addr  input  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
rd_busy  output  NUM_RD  1 = register on read port i has a pending (reserved) write
wr_en  input  NUM_WR  write enable per write port
wr_addr  input  NUM_WR*ADDR_W  write addresses
wr_data  input  NUM_WR*DATA_W  write data
rsv_en  input  1  reserve request for the register on rsv_addr
rsv_addr  input  ADDR_W  register to mark busy
busy_vec  output  2**ADDR_W  full scoreboard, bit k = register k busy

Behaviour:
- Reset (rst_n=0, asynchronous): all registers = 0; all busy bits = 0; rd_data = 0; rd_busy = 0; busy_vec = 0.
- Reads: combinational, zero latency.
  - rd_data[i] = reg[rd_addr[i]]; rd_busy[i] = busy[rd_addr[i]].
  - If ZERO_REG=1 and the address is 0, rd_data = 0 and rd_busy = 0.
- Writes: on rising clock, for each port j with wr_en[j]=1, reg[wr_addr[j]] <= wr_data[j].
  - Writes to address 0 are dropped when ZERO_REG=1.
  - Same address on several ports: the highest-index port wins.
- Scoreboard:
  - A write (wr_en[j], address a) clears busy[a] at the same edge.
  - rsv_en=1 sets busy[rsv_addr].
  - Reserve and write to the same register in one cycle: data is written and busy ends at 1 (reserve wins; the new producer supersedes the retiring one).
  - Reserve of a register already busy: stays 1, no error.
  - Write to a non-busy register: busy stays 0.
  - rsv_addr=0 with ZERO_REG=1 is ignored.
- Without the optional feature, a read in the same cycle as a write to that address returns the old value and the old busy bit. The new value is visible from the next cycle.
- Reset asserted mid-operation discards any same-cycle write/reserve. First post-reset edge with rst_n=1 behaves normally.

Optional Feature:
Macro REG_FILE_BYPASS_EN.
- Defined: write-through forwarding.
  - If any wr_en[j]=1 with wr_addr[j]==rd_addr[i] (nonzero when ZERO_REG=1), rd_data[i] = wr_data of the highest-index matching port in the same cycle.
  - rd_busy[i] = 0 unless rsv_en=1 with rsv_addr==rd_addr[i] in that cycle.
- Not defined: no forwarding; reads show stored state only, as above.

Decomposition:
- Package reg_file_pkg: default DATA_W/ADDR_W constants; a typedef for register address and data; a function computing DEPTH.
- One sub-module, reg_scoreboard: busy-bit array with reserve/release, priority and ZERO_REG handling, outputting busy_vec.
- The top level holds the storage array, write-port priority and read/bypass muxing.

Test Plan:
- Reset, then write 0xDEADBEEF to r5 via port 0; next cycle read r5 on port 1 -> 0xDEADBEEF; reads of all other registers -> 0.
- Port 0 writes 0x11111111 and port 1 writes 0x22222222 to r7 in the same cycle -> r7 reads 0x22222222.
- Write 0xFFFFFFFF to r0 and reserve r0 -> r0 reads 0, rd_busy=0, busy_vec[0]=0.
- Reserve r9 -> rd_busy=1 next cycle. Then same-cycle write r9=0x5 with reserve r9 -> data 0x5, busy stays 1. Then write r9=0x6 alone -> busy 0.
- Write r3=0xA5A5A5A5 while reading r3 in the same cycle -> 0x00000000 without REG_FILE_BYPASS_EN; 0xA5A5A5A5 with it.
- Registers loaded and r4 reserved, then assert rst_n low mid-cycle with wr_en high -> all outputs 0 immediately; after release, r4 reads 0 and is not busy.
